// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Writeback data forwards to all read ports in the same cycle; register 0 is hardwired to zero.
module regfile_scoreboard #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_RD    = 4,
    parameter int unsigned NUM_WR    = 2,
    parameter int unsigned NUM_ALLOC = 2,
    localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]        alloc_en,
    input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx,
    output logic [NUM_REGS-1:0]         busy_vec,
    output logic [IDX_W:0]              busy_count
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    // Next state: writes in ascending port order so the younger port wins; allocs override writes.
    always_comb begin : next_state
        regs_d  = regs_q;
        busy_d  = busy_q;
        count_d = '0;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en[j] && (wr_idx[j*IDX_W +: IDX_W] != '0)) begin
                regs_d[wr_idx[j*IDX_W +: IDX_W]] = wr_data[j*DATA_W +: DATA_W];
                busy_d[wr_idx[j*IDX_W +: IDX_W]] = 1'b0;
            end
        end
        for (int k = 0; k < int'(NUM_ALLOC); k++) begin
            if (alloc_en[k]) begin
                busy_d[alloc_idx[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            count_d = count_d + CNT_W'(busy_d[r]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin : state_regs
        if (reset) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Combinational read with forwarding from the highest-indexed matching write port.
    always_comb begin : read_ports
        rd_data  = '0;
        rd_ready = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_data[i*DATA_W +: DATA_W] = regs_q[rd_idx[i*IDX_W +: IDX_W]];
            rd_ready[i]                 = ~busy_q[rd_idx[i*IDX_W +: IDX_W]];
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && (wr_idx[j*IDX_W +: IDX_W] == rd_idx[i*IDX_W +: IDX_W])) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                    rd_ready[i]                 = 1'b1;
                end
            end
            if (reset || (rd_idx[i*IDX_W +: IDX_W] == '0)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_ready[i]                 = 1'b1;
            end
        end
    end

    assign busy_vec   = busy_q;
    assign busy_count = count_q;

endmodule
